// File: rtl/cu_vertex_cache_reuse_tag_control.sv
// Round-robin read-command arbiter with a small FIFO tag buffer that
// turns repeated 128-byte line requests into hit reports instead of reads.
module cu_vertex_cache_reuse_tag_control #(
  parameter int NUM_REQUESTERS  = 2,
  parameter int TAG_ENTRIES     = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                                 clock,
  input  logic                                 rstn_in,
  input  logic                                 enabled_in,
  input  logic                                 flush_in,
  input  logic [NUM_REQUESTERS-1:0]            req_valid_in,
  input  logic [NUM_REQUESTERS*64-1:0]         req_address_in,
  output logic [NUM_REQUESTERS-1:0]            req_grant_out,
  input  logic                                 read_buffer_full_in,
  input  logic                                 response_valid_in,
  output logic                                 cmd_valid_out,
  output logic [63:0]                          cmd_address_out,
  output logic [$clog2(NUM_REQUESTERS)-1:0]    cmd_requester_out,
  output logic                                 hit_valid_out,
  output logic [$clog2(NUM_REQUESTERS)-1:0]    hit_requester_out,
  output logic [$clog2(TAG_ENTRIES)-1:0]       hit_tag_index_out,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_out
);

  localparam int RW = $clog2(NUM_REQUESTERS);
  localparam int TW = $clog2(TAG_ENTRIES);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARB    = 3'd1;
  localparam logic [2:0] S_LOOKUP = 3'd2;
  localparam logic [2:0] S_HIT    = 3'd3;
  localparam logic [2:0] S_ISSUE  = 3'd4;

  // Reset asserts asynchronously, releases on the clock after rstn_in rises.
  logic rst_n_q;

  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      rst_n_q <= 1'b0;
    end else begin
      rst_n_q <= 1'b1;
    end
  end

  logic [2:0]                state_q, state_d;
  logic                      en_q;
  logic [RW-1:0]             rr_q, rr_d;
  logic [NUM_REQUESTERS-1:0] grant_q, grant_d;
  logic [56:0]               line_q, line_d;
  logic [RW-1:0]             req_q, req_d;
  logic [TW-1:0]             lk_idx_q, lk_idx_d;
  logic [TAG_ENTRIES-1:0]    valid_q, valid_d;
  logic [56:0]               tag_q [TAG_ENTRIES];
  logic [56:0]               tag_d [TAG_ENTRIES];
  logic [TW-1:0]             wptr_q, wptr_d;
  logic [OW-1:0]             cnt_q, cnt_d;
  logic                      cmd_valid_q, cmd_valid_d;
  logic [63:0]               cmd_addr_q, cmd_addr_d;
  logic [RW-1:0]             cmd_req_q, cmd_req_d;
  logic                      hit_valid_q, hit_valid_d;
  logic [RW-1:0]             hit_req_q, hit_req_d;
  logic [TW-1:0]             hit_idx_q, hit_idx_d;

  logic          arb_found;
  logic [RW-1:0] arb_idx;
  logic [RW:0]   cand;
  logic [RW:0]   rr_nxt;
  logic [56:0]   sel_line;
  logic          unused_addr_lsbs;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int o = 0; o < NUM_REQUESTERS; o++) begin
      cand = {1'b0, rr_q} + (RW+1)'(o);
      if (cand >= (RW+1)'(NUM_REQUESTERS)) begin
        cand = cand - (RW+1)'(NUM_REQUESTERS);
      end
      if (!arb_found && req_valid_in[cand[RW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[RW-1:0];
      end
    end
  end

  always_comb begin
    rr_nxt = {1'b0, arb_idx} + (RW+1)'(1);
    if (rr_nxt == (RW+1)'(NUM_REQUESTERS)) begin
      rr_nxt = '0;
    end
  end

  always_comb begin
    sel_line = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (arb_idx == RW'(i)) begin
        sel_line = req_address_in[i*64+7 +: 57];
      end
    end
  end

  // Low seven bits only select a byte within the line.
  always_comb begin
    unused_addr_lsbs = 1'b0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      unused_addr_lsbs = unused_addr_lsbs ^ (^req_address_in[i*64 +: 7]);
    end
  end

  logic          hit_any;
  logic [TW-1:0] hit_idx;

  // Descending scan so the lowest matching entry wins.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int e = TAG_ENTRIES - 1; e >= 0; e--) begin
      if (valid_q[e] && (tag_q[e] == line_q)) begin
        hit_any = 1'b1;
        hit_idx = TW'(e);
      end
    end
  end

  logic stall;
  logic issue_fire;
  logic resp_dec;

  assign stall      = read_buffer_full_in ||
                      (cnt_q == OW'(MAX_OUTSTANDING));
  assign issue_fire = (state_q == S_ISSUE) && !stall;
  assign resp_dec   = response_valid_in && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (issue_fire && !resp_dec) begin
      cnt_d = cnt_q + OW'(1);
    end else if (!issue_fire && resp_dec) begin
      cnt_d = cnt_q - OW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = '0;
    line_d      = line_q;
    req_d       = req_q;
    lk_idx_d    = lk_idx_q;
    valid_d     = flush_in ? '0 : valid_q;
    tag_d       = tag_q;
    wptr_d      = wptr_q;
    cmd_valid_d = 1'b0;
    cmd_addr_d  = cmd_addr_q;
    cmd_req_d   = cmd_req_q;
    hit_valid_d = 1'b0;
    hit_req_d   = hit_req_q;
    hit_idx_d   = hit_idx_q;
    case (state_q)
      S_IDLE: begin
        if (en_q) begin
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end else if (arb_found) begin
          grant_d = NUM_REQUESTERS'(1) << arb_idx;
          req_d   = arb_idx;
          line_d  = sel_line;
          rr_d    = rr_nxt[RW-1:0];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit_any && !flush_in) begin
          lk_idx_d = hit_idx;
          state_d  = S_HIT;
        end else begin
          state_d  = S_ISSUE;
        end
      end
      S_HIT: begin
        hit_valid_d = 1'b1;
        hit_req_d   = req_q;
        hit_idx_d   = lk_idx_q;
        state_d     = S_ARB;
      end
      S_ISSUE: begin
        if (!stall) begin
          cmd_valid_d    = 1'b1;
          cmd_addr_d     = {line_q, 7'b0};
          cmd_req_d      = req_q;
          tag_d[wptr_q]  = line_q;
          if (!flush_in) begin
            valid_d[wptr_q] = 1'b1;
          end
          wptr_d         = wptr_q + TW'(1);
          state_d        = S_ARB;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q     <= S_IDLE;
      en_q        <= 1'b0;
      rr_q        <= '0;
      grant_q     <= '0;
      line_q      <= '0;
      req_q       <= '0;
      lk_idx_q    <= '0;
      valid_q     <= '0;
      tag_q       <= '{default: '0};
      wptr_q      <= '0;
      cnt_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_req_q   <= '0;
      hit_valid_q <= 1'b0;
      hit_req_q   <= '0;
      hit_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= enabled_in;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      line_q      <= line_d;
      req_q       <= req_d;
      lk_idx_q    <= lk_idx_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_req_q   <= cmd_req_d;
      hit_valid_q <= hit_valid_d;
      hit_req_q   <= hit_req_d;
      hit_idx_q   <= hit_idx_d;
    end
  end

  assign req_grant_out     = grant_q;
  assign cmd_valid_out     = cmd_valid_q;
  assign cmd_address_out   = cmd_addr_q;
  assign cmd_requester_out = cmd_req_q;
  assign hit_valid_out     = hit_valid_q;
  assign hit_requester_out = hit_req_q;
  assign hit_tag_index_out = hit_idx_q;
  assign outstanding_out   = cnt_q;

endmodule

// File: tb/tb_cu_vertex_cache_reuse_tag_control.sv
// Directed bench for the vertex-cache tag control: arbitration, hits,
// FIFO replacement, stalls, flush, response saturation and reset.
module tb_cu_vertex_cache_reuse_tag_control;

  logic         clock;
  logic         rstn_in;
  logic         enabled_in;
  logic         flush_in;
  logic [1:0]   req_valid_in;
  logic [127:0] req_address_in;
  logic [1:0]   req_grant_out;
  logic         read_buffer_full_in;
  logic         response_valid_in;
  logic         cmd_valid_out;
  logic [63:0]  cmd_address_out;
  logic [0:0]   cmd_requester_out;
  logic         hit_valid_out;
  logic [0:0]   hit_requester_out;
  logic [1:0]   hit_tag_index_out;
  logic [4:0]   outstanding_out;

  cu_vertex_cache_reuse_tag_control #(
    .NUM_REQUESTERS (2),
    .TAG_ENTRIES    (4),
    .MAX_OUTSTANDING(16)
  ) dut (
    .clock              (clock),
    .rstn_in            (rstn_in),
    .enabled_in         (enabled_in),
    .flush_in           (flush_in),
    .req_valid_in       (req_valid_in),
    .req_address_in     (req_address_in),
    .req_grant_out      (req_grant_out),
    .read_buffer_full_in(read_buffer_full_in),
    .response_valid_in  (response_valid_in),
    .cmd_valid_out      (cmd_valid_out),
    .cmd_address_out    (cmd_address_out),
    .cmd_requester_out  (cmd_requester_out),
    .hit_valid_out      (hit_valid_out),
    .hit_requester_out  (hit_requester_out),
    .hit_tag_index_out  (hit_tag_index_out),
    .outstanding_out    (outstanding_out)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_cmd = 0;
  int n_hit = 0;
  logic [63:0] cmd_log [$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (cmd_valid_out) begin
      n_cmd = n_cmd + 1;
      cmd_log.push_back(cmd_address_out);
    end
    if (hit_valid_out) n_hit = n_hit + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    rstn_in = 1'b0;
    req_valid_in = '0;
    flush_in = 1'b0;
    read_buffer_full_in = 1'b0;
    response_valid_in = 1'b0;
    idle(2);
    rstn_in = 1'b1;
    idle(4);
  endtask

  task automatic pulse_resp();
    response_valid_in = 1'b1;
    @(negedge clock);
    response_valid_in = 1'b0;
  endtask

  task automatic wait_grant(input int r, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      if (req_grant_out[r]) got = 1'b1;
    end
    check({tag, " grant"}, 64'(got), 64'd1);
    req_valid_in[r] = 1'b0;
  endtask

  task automatic wait_result(input string tag, output bit h);
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clock);
      if (hit_valid_out || cmd_valid_out) done = 1'b1;
    end
    check({tag, " result"}, 64'(done), 64'd1);
    h = hit_valid_out;
  endtask

  task automatic do_req(input int r, input logic [63:0] a,
                        input bit exp_hit, input string tag);
    int g;
    bit h;
    req_address_in[r*64 +: 64] = a;
    req_valid_in[r] = 1'b1;
    wait_grant(r, tag);
    g = cyc;
    wait_result(tag, h);
    check({tag, " hit"}, 64'(h), 64'(exp_hit));
    check({tag, " latency"}, 64'(cyc - g), 64'd2);
  endtask

  logic [1:0] gseq [3];
  int ng;
  int c0;
  int h0;
  int seen;
  int gcnt;
  bit hflag;

  initial begin
    rstn_in = 1'b0;
    enabled_in = 1'b0;
    flush_in = 1'b0;
    req_valid_in = '0;
    req_address_in = '0;
    read_buffer_full_in = 1'b0;
    response_valid_in = 1'b0;

    idle(3);
    check("rst grant", 64'(req_grant_out), 64'd0);
    check("rst cmd_valid", 64'(cmd_valid_out), 64'd0);
    check("rst hit_valid", 64'(hit_valid_out), 64'd0);
    check("rst outstanding", 64'(outstanding_out), 64'd0);
    check("rst cmd_addr", cmd_address_out, 64'd0);
    rstn_in = 1'b1;
    enabled_in = 1'b1;
    idle(4);

    // Same 128-byte line: second request hits entry 0.
    do_req(0, 64'h1040, 1'b0, "line miss");
    check("line cmd_addr", cmd_address_out, 64'h1000);
    check("line cmd_req", 64'(cmd_requester_out), 64'd0);
    check("line outstanding", 64'(outstanding_out), 64'd1);
    do_req(0, 64'h1000, 1'b1, "line hit");
    check("line hit idx", 64'(hit_tag_index_out), 64'd0);
    check("line hit req", 64'(hit_requester_out), 64'd0);

    // Two always-valid requesters alternate.
    do_reset();
    c0 = cmd_log.size();
    h0 = n_hit;
    ng = 0;
    req_address_in = {64'h2000, 64'h1000};
    req_valid_in = 2'b11;
    for (int i = 0; i < 40 && ng < 3; i++) begin
      @(negedge clock);
      if (|req_grant_out) begin
        gseq[ng] = req_grant_out;
        ng++;
      end
    end
    req_valid_in = '0;
    idle(6);
    check("rr grants", 64'(ng), 64'd3);
    check("rr g0", 64'(gseq[0]), 64'h1);
    check("rr g1", 64'(gseq[1]), 64'h2);
    check("rr g2", 64'(gseq[2]), 64'h1);
    check("rr ncmd", 64'(cmd_log.size() - c0), 64'd2);
    check("rr cmd0", cmd_log[c0], 64'h1000);
    check("rr cmd1", cmd_log[c0+1], 64'h2000);
    check("rr nhit", 64'(n_hit - h0), 64'd1);
    check("rr outstanding", 64'(outstanding_out), 64'd2);

    pulse_resp();
    pulse_resp();
    #1;
    check("resp drain", 64'(outstanding_out), 64'd0);
    pulse_resp();
    #1;
    check("resp at zero", 64'(outstanding_out), 64'd0);

    // FIFO wrap: five lines into four entries.
    do_reset();
    for (int l = 1; l <= 5; l++) begin
      do_req(0, 64'(l) * 64'h80, 1'b0, "wrap fill");
    end
    do_req(0, 64'h80, 1'b0, "wrap line1");
    check("wrap line1 addr", cmd_address_out, 64'h80);
    do_req(0, 64'h280, 1'b1, "wrap line5");
    check("wrap line5 idx", 64'(hit_tag_index_out), 64'd0);
    check("wrap outstanding", 64'(outstanding_out), 64'd6);

    // Buffer-full stall with a second requester waiting.
    do_reset();
    c0 = n_cmd;
    read_buffer_full_in = 1'b1;
    req_address_in = {64'hA000, 64'h9000};
    req_valid_in = 2'b11;
    wait_grant(0, "full");
    seen = 0;
    gcnt = 0;
    repeat (10) begin
      @(negedge clock);
      if (cmd_valid_out) seen++;
      if (|req_grant_out) gcnt++;
    end
    check("full no cmd", 64'(seen), 64'd0);
    check("full no grant", 64'(gcnt), 64'd0);
    read_buffer_full_in = 1'b0;
    @(negedge clock);
    check("full release cmd", 64'(cmd_valid_out), 64'd1);
    check("full release addr", cmd_address_out, 64'h9000);
    wait_grant(1, "full r1");
    idle(4);
    check("full ncmd", 64'(n_cmd - c0), 64'd2);
    check("full last addr", cmd_log[cmd_log.size()-1], 64'hA000);
    check("full outstanding", 64'(outstanding_out), 64'd2);

    // Outstanding limit stall.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      do_req(0, 64'h10000 + 64'(i) * 64'h80, 1'b0, "lim fill");
    end
    check("lim full count", 64'(outstanding_out), 64'd16);
    req_address_in[63:0] = 64'h20000;
    req_valid_in[0] = 1'b1;
    wait_grant(0, "lim");
    seen = 0;
    repeat (5) begin
      @(negedge clock);
      if (cmd_valid_out) seen++;
    end
    check("lim no cmd", 64'(seen), 64'd0);
    check("lim held", 64'(outstanding_out), 64'd16);
    pulse_resp();
    check("lim after resp", 64'(outstanding_out), 64'd15);
    check("lim still stalled", 64'(cmd_valid_out), 64'd0);
    @(negedge clock);
    check("lim issue", 64'(cmd_valid_out), 64'd1);
    check("lim issue addr", cmd_address_out, 64'h20000);
    check("lim refilled", 64'(outstanding_out), 64'd16);

    // Flush on the issue edge.
    do_reset();
    do_req(0, 64'h3000, 1'b0, "flush pre");
    req_address_in[63:0] = 64'h4000;
    req_valid_in[0] = 1'b1;
    wait_grant(0, "flush");
    @(negedge clock);
    flush_in = 1'b1;
    @(negedge clock);
    flush_in = 1'b0;
    check("flush issued", 64'(cmd_valid_out), 64'd1);
    check("flush addr", cmd_address_out, 64'h4000);
    do_req(0, 64'h4000, 1'b0, "flush same");
    do_req(0, 64'h3000, 1'b0, "flush older");

    // Reset while in LOOKUP.
    do_reset();
    do_req(0, 64'h5000, 1'b0, "mid pre");
    req_address_in[63:0] = 64'h5000;
    req_valid_in[0] = 1'b1;
    wait_grant(0, "mid");
    rstn_in = 1'b0;
    #1;
    check("mid grant", 64'(req_grant_out), 64'd0);
    check("mid cmd_valid", 64'(cmd_valid_out), 64'd0);
    check("mid hit_valid", 64'(hit_valid_out), 64'd0);
    check("mid outstanding", 64'(outstanding_out), 64'd0);
    check("mid cmd_addr", cmd_address_out, 64'd0);
    idle(2);
    rstn_in = 1'b1;
    idle(4);
    req_address_in = {64'h6000, 64'h5000};
    req_valid_in = 2'b11;
    gcnt = 0;
    gseq[0] = '0;
    for (int i = 0; i < 50 && gcnt == 0; i++) begin
      @(negedge clock);
      if (|req_grant_out) begin
        gseq[0] = req_grant_out;
        gcnt++;
      end
    end
    req_valid_in = '0;
    check("post grant r0", 64'(gseq[0]), 64'h1);
    wait_result("post", hflag);
    check("post miss", 64'(hflag), 64'd0);
    check("post addr", cmd_address_out, 64'h5000);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cu_vertex_cache_reuse_tag_control.md
# cu_vertex_cache_reuse_tag_control

Arbitrates vertex-data read commands from several requesters onto the single read command port of the PageRank pull-mode global compute unit. Before issue, each command is filtered through a small fully-associative tag buffer of recently issued 128-byte cacheline addresses. A hit is reported back to the requester instead of being re-issued to memory; a miss is issued downstream subject to buffer-full and outstanding-request limits. It sits upstream of the vertex cache reuse datapath and supplies that datapath's cache-miss decision.

## Interface
- NUM_REQUESTERS, 2, number of command requesters (≥2)
- TAG_ENTRIES, 4, tag buffer entries (power of two)
- MAX_OUTSTANDING, 16, maximum issued-but-unanswered commands
- clock  in  1  single clock, all logic on rising edge
- rstn_in  in  1  asynchronous active-low reset; internal reset asserts immediately and releases one clock after rstn_in rises
- enabled_in  in  1  unit enable, registered internally (one-cycle delay)
- flush_in  in  1  invalidate all tag entries
- req_valid_in  in  NUM_REQUESTERS  per-requester command valid, held until granted
- req_address_in  in  NUM_REQUESTERS*64  per-requester byte address, requester i at bits [64i+63:64i]
- req_grant_out  out  NUM_REQUESTERS  one-hot, one-cycle accept pulse
- read_buffer_full_in  in  1  downstream read command buffer full
- response_valid_in  in  1  one pulse per completed issued command
- cmd_valid_out  out  1  one-cycle issue pulse
- cmd_address_out  out  64  line-aligned address {line, 7'b0}
- cmd_requester_out  out  $clog2(NUM_REQUESTERS)  originator of issued command
- hit_valid_out  out  1  one-cycle hit pulse
- hit_requester_out  out  $clog2(NUM_REQUESTERS)  originator of hit
- hit_tag_index_out  out  $clog2(TAG_ENTRIES)  matching entry
- outstanding_out  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count

## Operation
- Line tag = address[63:7]. Each entry holds a valid bit and a 57-bit tag. Replacement is FIFO: a write pointer starts at 0, advances on every tag write, and wraps from TAG_ENTRIES-1 to 0.
- FSM states: IDLE, ARB, LOOKUP, HIT, ISSUE.
- IDLE: entered on reset and whenever enabled is low in ARB. Goes to ARB when enabled is high.
- ARB: if enabled is low, go to IDLE. If any req_valid_in bit is set, grant the highest-priority valid requester under round-robin, capture its address and index, pulse req_grant_out, and go to LOOKUP. Otherwise stay in ARB.
- Round-robin: after reset, requester 0 has highest priority. After a grant to requester i, priority starts at (i+1) mod NUM_REQUESTERS.
- LOOKUP: compare the captured tag against all valid entries. On a match go to HIT, recording the lowest matching index. Otherwise go to ISSUE. If flush_in is high in this cycle, the result is forced to miss.
- HIT: pulse hit_valid_out with the requester and index, then return to ARB. No command is issued and the tags are unchanged.
- ISSUE: stall while read_buffer_full_in is high or outstanding == MAX_OUTSTANDING. When clear: pulse cmd_valid_out, write the tag at the write pointer (valid=1), advance the pointer, increment outstanding, and return to ARB.
- Outstanding counter: +1 on issue, −1 on response_valid_in. A simultaneous issue and response leaves it unchanged. A response arriving at 0 is ignored (saturates, no underflow).
- flush_in: clears every valid bit at the next edge in any state. It takes priority over a same-cycle tag write; the command is still issued. The write pointer is not reset.
- Disable mid-request: the current request completes through HIT/ISSUE, then the FSM goes to IDLE. Tags and the counter are retained.
- Reset mid-operation: all state, tags, pointer and counter clear, and the in-flight request is dropped.
- Reset values: all outputs 0; FSM in IDLE.

## Timing
- Every output is registered.
- Grant is sampled at edge k in ARB. req_grant_out is high for cycle k..k+1.
- The requester may drop valid or change its address from edge k+1 onward.
- Hit path: hit_valid_out is high for cycle k+2..k+3.
- Unstalled miss path: cmd_valid_out is high for cycle k+2..k+3. Each stall cycle adds one.
- The next grant is possible at edge k+3, so peak throughput is one request per 3 cycles.
- A tag written at issue edge e is visible to a LOOKUP at edge e+2 or later, which covers every subsequent request.
- The registered enabled adds one cycle before leaving IDLE.

## Test plan
- Two requesters both always valid with distinct addresses 0x1000 and 0x2000 → grants alternate r0, r1, r0. Two cmd_valid_out pulses with addresses 0x1000 and 0x2000. outstanding_out = 2.
- r0 requests 0x1040, then 0x1000 → the second request gives hit_valid_out with index 0 and no cmd_valid_out. Same 128-byte line.
- Issue 5 distinct lines with TAG_ENTRIES=4 → the pointer wraps. Re-requesting line 1 misses. Line 5 hits at index 0.
- Hold read_buffer_full_in high for 10 cycles during ISSUE → no cmd_valid_out and no further grants. Issue occurs one cycle after full drops. Repeat the test by reaching outstanding = 16.
- Assert flush_in in the same cycle as an ISSUE write → the command is issued, and a later identical request misses. A response_valid_in at outstanding 0 leaves the count at 0.
- Assert rstn_in low during LOOKUP → all outputs 0 immediately. After release, requester 0 has priority and all tags are invalid.
